// File: rtl/calc_seq_ctrl_if.sv
// Board-input and ALU handshake bundle for the MiniCalculator sequencing controller.
// master = controller side, slave = ALU / board / display side.
interface calc_seq_ctrl_if #(
   parameter int unsigned OP_W = 4
);
   localparam int unsigned DW = 2 * OP_W;

   logic [3:0]      btn_i;
   logic [DW-1:0]   sw_i;
   logic            alu_start_o;
   logic [1:0]      alu_op_o;
   logic [OP_W-1:0] alu_a_o;
   logic [OP_W-1:0] alu_b_o;
   logic            alu_done_i;
   logic [DW-1:0]   alu_result_i;
   logic            alu_err_i;
   logic [DW-1:0]   disp_val_o;
   logic            busy_o;
   logic            led_o;

   modport master (
      input  btn_i, sw_i, alu_done_i, alu_result_i, alu_err_i,
      output alu_start_o, alu_op_o, alu_a_o, alu_b_o, disp_val_o, busy_o, led_o
   );

   modport slave (
      output btn_i, sw_i, alu_done_i, alu_result_i, alu_err_i,
      input  alu_start_o, alu_op_o, alu_a_o, alu_b_o, disp_val_o, busy_o, led_o
   );
endinterface

// File: rtl/calc_seq_ctrl.sv
// MiniCalculator sequencing controller: button edge detect, operand latch, ALU start/wait, display/error.
// Optional WAIT timeout enabled by defining CALC_SEQ_CTRL_TIMEOUT_EN.
module calc_seq_ctrl #(
   parameter int unsigned OP_W = 4
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
   , parameter int unsigned TIMEOUT = 64
`endif
) (
   input  logic              clk,
   input  logic              rst,
   calc_seq_ctrl_if.master   bus
);
   localparam int unsigned DW = 2 * OP_W;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [OP_W-1:0] a_q, a_d;
   logic [OP_W-1:0] b_q, b_d;
   logic [DW-1:0]   res_q, res_d;
   logic            show_res_q, show_res_d;
   logic [3:0]      btn_q;
   logic            start_q, busy_q, led_q;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   logic [3:0]      press;
   logic            clr, exe, nxt, tgl, div0;
   logic [OP_W-1:0] sw_a, sw_b;

   assign sw_a = bus.sw_i[DW-1:OP_W];
   assign sw_b = bus.sw_i[OP_W-1:0];

   // Rising-edge presses, resolved to a single command: clear > execute > next op > toggle
   assign press = bus.btn_i & ~btn_q;
   assign clr   = press[1];
   assign exe   = ~press[1] & press[3];
   assign nxt   = ~press[1] & ~press[3] & press[0];
   assign tgl   = ~press[1] & ~press[3] & ~press[0] & press[2];
   assign div0  = (op_q == 2'd3) && (sw_b == '0);

   // Next-state and datapath-register update
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      show_res_d = show_res_q;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      if (clr) begin
         state_d    = S_IDLE;
         res_d      = '0;
         show_res_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (exe) begin
                  if (div0) begin
                     state_d = S_ERR;
                  end else begin
                     a_d     = sw_a;
                     b_d     = sw_b;
                     state_d = S_ISSUE;
                  end
               end else if (nxt) begin
                  op_d    = op_q + 2'd1;
                  state_d = S_IDLE;
               end else if (tgl) begin
                  show_res_d = ~show_res_q;
               end
            end
            S_ISSUE: begin
               state_d = S_WAIT;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
            S_WAIT: begin
               // A done pulse in the final timeout cycle still wins
               if (bus.alu_done_i) begin
                  res_d      = bus.alu_result_i;
                  show_res_d = 1'b1;
                  state_d    = bus.alu_err_i ? S_ERR : S_DONE;
               end
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_d = S_ERR;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
            S_ERR: begin
               state_d = S_ERR;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         show_res_q <= 1'b0;
         btn_q      <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         led_q      <= 1'b0;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         show_res_q <= show_res_d;
         btn_q      <= bus.btn_i;
         start_q    <= (state_d == S_ISSUE);
         busy_q     <= (state_d == S_ISSUE) || (state_d == S_WAIT);
         led_q      <= (state_d == S_ERR);
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign bus.alu_start_o = start_q;
   assign bus.alu_op_o    = op_q;
   assign bus.alu_a_o     = a_q;
   assign bus.alu_b_o     = b_q;
   assign bus.busy_o      = busy_q;
   assign bus.led_o       = led_q;

   // Operand view follows the switches live; error forces all segments on
   assign bus.disp_val_o  = (state_q == S_ERR) ? '1 :
                            (show_res_q ? res_q : bus.sw_i);
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed vector table, timeout sequence, randomized model compare.
module tb_calc_seq_ctrl;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst;

   calc_seq_ctrl_if #(.OP_W(OP_W)) bus ();

   calc_seq_ctrl #(.OP_W(OP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] btn, input logic [7:0] sw, input logic done,
                        input logic [7:0] res, input logic err);
      bus.btn_i        = btn;
      bus.sw_i         = sw;
      bus.alu_done_i   = done;
      bus.alu_result_i = res;
      bus.alu_err_i    = err;
   endtask

   typedef struct {
      logic [3:0] btn;
      logic [7:0] sw;
      logic       done;
      logic [7:0] res;
      logic       err;
      logic       e_start;
      logic       e_busy;
      logic       e_led;
      logic [1:0] e_op;
      logic [3:0] e_a;
      logic [3:0] e_b;
      logic [7:0] e_disp;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] btn, input logic [7:0] sw, input logic done,
                               input logic [7:0] res, input logic err, input logic e_start,
                               input logic e_busy, input logic e_led, input logic [1:0] e_op,
                               input logic [3:0] e_a, input logic [3:0] e_b, input logic [7:0] e_disp);
      vec_t v;
      v.btn = btn; v.sw = sw; v.done = done; v.res = res; v.err = err;
      v.e_start = e_start; v.e_busy = e_busy; v.e_led = e_led; v.e_op = e_op;
      v.e_a = e_a; v.e_b = e_b; v.e_disp = e_disp;
      return v;
   endfunction

   task automatic check_all(input string tag, input logic e_start, input logic e_busy,
                            input logic e_led, input logic [1:0] e_op, input logic [3:0] e_a,
                            input logic [3:0] e_b, input logic [7:0] e_disp);
      check({tag, " start"}, 16'(bus.alu_start_o), 16'(e_start));
      check({tag, " busy"},  16'(bus.busy_o),      16'(e_busy));
      check({tag, " led"},   16'(bus.led_o),       16'(e_led));
      check({tag, " op"},    16'(bus.alu_op_o),    16'(e_op));
      check({tag, " a"},     16'(bus.alu_a_o),     16'(e_a));
      check({tag, " b"},     16'(bus.alu_b_o),     16'(e_b));
      check({tag, " disp"},  16'(bus.disp_val_o),  16'(e_disp));
   endtask

   // Behavioural reference: the calculator as the user sees it
   typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_DONE, M_ERR} mode_t;
   mode_t      m_mode;
   logic [1:0] m_op;
   logic [3:0] m_a, m_b;
   logic [7:0] m_res;
   bit         m_show_res;
   logic [3:0] m_prev;
   int         m_wait_cycles;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   task automatic model_reset();
      m_mode = M_IDLE; m_op = 0; m_a = 0; m_b = 0; m_res = 0;
      m_show_res = 0; m_prev = 0; m_wait_cycles = 0;
   endtask

   task automatic model_edge(input logic [3:0] btn, input logic [7:0] sw, input logic done,
                             input logic [7:0] res, input logic err);
      logic [3:0] p;
      p = btn & ~m_prev;
      m_prev = btn;
      if (p[1]) begin
         m_mode = M_IDLE; m_res = 0; m_show_res = 0;
      end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
         if (p[3]) begin
            if (m_op == 3 && sw[3:0] == 0) m_mode = M_ERR;
            else begin
               m_a = sw[7:4]; m_b = sw[3:0]; m_mode = M_ISSUE;
            end
         end else if (p[0]) begin
            m_op = (m_op + 1) % 4; m_mode = M_IDLE;
         end else if (p[2]) begin
            m_show_res = !m_show_res;
         end
      end else if (m_mode == M_ISSUE) begin
         m_mode = M_WAIT; m_wait_cycles = 1;
      end else if (m_mode == M_WAIT) begin
         if (done) begin
            m_res = res; m_show_res = 1; m_mode = err ? M_ERR : M_DONE;
         end else if (TO_EN && m_wait_cycles >= TIMEOUT) begin
            m_mode = M_ERR;
         end else begin
            m_wait_cycles++;
         end
      end
   endtask

   vec_t tbl[39];

   initial begin
      tbl[0]  = mk(4'h8, 8'h22, 0, 8'h00, 0, 1, 1, 0, 0, 4'h2, 4'h2, 8'h22);
      tbl[1]  = mk(4'h8, 8'h22, 0, 8'h00, 0, 0, 1, 0, 0, 4'h2, 4'h2, 8'h22);
      tbl[2]  = mk(4'h8, 8'h22, 0, 8'h00, 0, 0, 1, 0, 0, 4'h2, 4'h2, 8'h22);
      tbl[3]  = mk(4'h0, 8'h22, 1, 8'h04, 0, 0, 0, 0, 0, 4'h2, 4'h2, 8'h04);
      tbl[4]  = mk(4'h0, 8'h22, 0, 8'h00, 0, 0, 0, 0, 0, 4'h2, 4'h2, 8'h04);
      tbl[5]  = mk(4'h1, 8'h22, 0, 8'h00, 0, 0, 0, 0, 1, 4'h2, 4'h2, 8'h04);
      tbl[6]  = mk(4'h0, 8'h22, 0, 8'h00, 0, 0, 0, 0, 1, 4'h2, 4'h2, 8'h04);
      tbl[7]  = mk(4'h1, 8'h22, 0, 8'h00, 0, 0, 0, 0, 2, 4'h2, 4'h2, 8'h04);
      tbl[8]  = mk(4'h0, 8'h22, 0, 8'h00, 0, 0, 0, 0, 2, 4'h2, 4'h2, 8'h04);
      tbl[9]  = mk(4'h1, 8'h22, 0, 8'h00, 0, 0, 0, 0, 3, 4'h2, 4'h2, 8'h04);
      tbl[10] = mk(4'h0, 8'h50, 0, 8'h00, 0, 0, 0, 0, 3, 4'h2, 4'h2, 8'h04);
      tbl[11] = mk(4'h8, 8'h50, 0, 8'h00, 0, 0, 0, 1, 3, 4'h2, 4'h2, 8'hFF);
      tbl[12] = mk(4'h0, 8'h50, 0, 8'h00, 0, 0, 0, 1, 3, 4'h2, 4'h2, 8'hFF);
      tbl[13] = mk(4'h2, 8'h50, 0, 8'h00, 0, 0, 0, 0, 3, 4'h2, 4'h2, 8'h50);
      tbl[14] = mk(4'h0, 8'h50, 0, 8'h00, 0, 0, 0, 0, 3, 4'h2, 4'h2, 8'h50);
      tbl[15] = mk(4'h1, 8'h50, 0, 8'h00, 0, 0, 0, 0, 0, 4'h2, 4'h2, 8'h50);
      tbl[16] = mk(4'h0, 8'h50, 0, 8'h00, 0, 0, 0, 0, 0, 4'h2, 4'h2, 8'h50);
      tbl[17] = mk(4'h1, 8'h50, 0, 8'h00, 0, 0, 0, 0, 1, 4'h2, 4'h2, 8'h50);
      tbl[18] = mk(4'h0, 8'h50, 0, 8'h00, 0, 0, 0, 0, 1, 4'h2, 4'h2, 8'h50);
      tbl[19] = mk(4'h1, 8'h50, 0, 8'h00, 0, 0, 0, 0, 2, 4'h2, 4'h2, 8'h50);
      tbl[20] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'h2, 4'h2, 8'hF3);
      tbl[21] = mk(4'h8, 8'hF3, 0, 8'h00, 0, 1, 1, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[22] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 1, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[23] = mk(4'h0, 8'hF3, 1, 8'h2D, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'h2D);
      tbl[24] = mk(4'h4, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[25] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[26] = mk(4'h4, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'h2D);
      tbl[27] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'h2D);
      tbl[28] = mk(4'h2, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[29] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[30] = mk(4'hA, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[31] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[32] = mk(4'h0, 8'hF3, 1, 8'h77, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[33] = mk(4'h8, 8'hF3, 0, 8'h00, 0, 1, 1, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[34] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 1, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[35] = mk(4'h2, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[36] = mk(4'h0, 8'hF3, 1, 8'h99, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'hF3);
      tbl[37] = mk(4'h4, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'h00);
      tbl[38] = mk(4'h0, 8'hF3, 0, 8'h00, 0, 0, 0, 0, 2, 4'hF, 4'h3, 8'h00);

      // Reset
      rst = 1'b1;
      drive(4'h0, 8'h22, 0, 8'h00, 0);
      step();
      rst = 1'b0;
      check_all("reset", 0, 0, 0, 0, 4'h0, 4'h0, 8'h22);

      // Directed table: add, div-by-zero, mul/toggle, priority, clear mid-op
      for (int i = 0; i < 39; i++) begin
         drive(tbl[i].btn, tbl[i].sw, tbl[i].done, tbl[i].res, tbl[i].err);
         step();
         check_all($sformatf("v%0d", i), tbl[i].e_start, tbl[i].e_busy, tbl[i].e_led,
                   tbl[i].e_op, tbl[i].e_a, tbl[i].e_b, tbl[i].e_disp);
      end

      // ALU error flag returned with done
      drive(4'h8, 8'h31, 0, 8'h00, 0);
      step();
      drive(4'h0, 8'h31, 0, 8'h00, 0);
      step();
      drive(4'h0, 8'h31, 1, 8'h12, 1);
      step();
      check_all("alu_err", 0, 0, 1, 2, 4'h3, 4'h1, 8'hFF);
      drive(4'h2, 8'h31, 0, 8'h00, 0);
      step();
      check("alu_err clear led", 16'(bus.led_o), 16'h0);
      drive(4'h0, 8'h31, 0, 8'h00, 0);
      step();

      // WAIT with no done pulse
      drive(4'h8, 8'h21, 0, 8'h00, 0);
      step();
      check("to issue start", 16'(bus.alu_start_o), 16'h1);
      drive(4'h0, 8'h21, 0, 8'h00, 0);
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
      for (int i = 0; i < TIMEOUT; i++) step();
      check("to wait64 busy", 16'(bus.busy_o), 16'h1);
      check("to wait64 led",  16'(bus.led_o),  16'h0);
      step();
      check("to err led",  16'(bus.led_o),      16'h1);
      check("to err busy", 16'(bus.busy_o),     16'h0);
      check("to err disp", 16'(bus.disp_val_o), 16'hFF);
`else
      for (int i = 0; i < 200; i++) step();
      check("no-to busy", 16'(bus.busy_o), 16'h1);
      check("no-to led",  16'(bus.led_o),  16'h0);
`endif
      drive(4'h2, 8'h21, 0, 8'h00, 0);
      step();
      check("to clear busy", 16'(bus.busy_o), 16'h0);
      check("to clear led",  16'(bus.led_o),  16'h0);

      // Randomized run against the reference model
      rst = 1'b1;
      drive(4'h0, 8'h00, 0, 8'h00, 0);
      step();
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         logic [3:0] btn;
         logic [7:0] sw;
         logic [7:0] r;
         logic       d, e;
         btn = bus.btn_i;
         if ($urandom_range(39) == 0) btn[1] = ~btn[1];
         if ($urandom_range(4) == 0)  btn[0] = ~btn[0];
         if ($urandom_range(4) == 0)  btn[2] = ~btn[2];
         if ($urandom_range(4) == 0)  btn[3] = ~btn[3];
         sw = bus.sw_i;
         if ($urandom_range(3) == 0) begin
            sw = 8'($urandom);
            if ($urandom_range(2) == 0) sw[3:0] = 4'h0;
         end
         d = ($urandom_range(3) == 0);
         r = 8'($urandom);
         e = ($urandom_range(7) == 0);
         drive(btn, sw, d, r, e);
         step();
         model_edge(btn, sw, d, r, e);
         check_all($sformatf("rnd%0d", c), m_mode == M_ISSUE,
                   m_mode == M_ISSUE || m_mode == M_WAIT, m_mode == M_ERR,
                   m_op, m_a, m_b, (m_mode == M_ERR) ? 8'hFF : (m_show_res ? m_res : sw));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
